// File: rtl/pixel_assembler.sv
// Packs three UART bytes (R, G, B) into one 24-bit pixel with a valid/ready output.
// Optional macro PIXEL_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module pixel_assembler #(
    parameter int unsigned IDLE_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        data_ready,
    input  logic        overrun_error,
    input  logic        framing_error,
    output logic        data_read,
    output logic [23:0] pixel_out,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        sync_error
`ifdef PIXEL_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_R,
        WAIT_G,
        WAIT_B,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;
    logic        r_read_prev;
    logic        r_sync;
    logic [15:0] r_idle;
    logic [15:0] w_idle_nxt;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [23:0] r_pixel;
    logic        w_in_gb;
    logic        w_accept;
    logic        w_drop;
    logic        w_timeout;
    logic        w_sync_nxt;

    // r_armed holds off accepts until the first edge after reset release.
    always_comb begin
        w_in_gb   = (r_state == WAIT_G) || (r_state == WAIT_B);
        w_accept  = r_armed && (r_state != HOLD) && data_ready && !r_read_prev;
        w_drop    = (r_state != HOLD) && (overrun_error || (w_accept && framing_error));
        w_timeout = w_in_gb && !w_accept && (r_idle == TIMEOUT_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sync_nxt  = 1'b0;
        if (w_drop) begin
            w_state_nxt = WAIT_R;
            w_sync_nxt  = 1'b1;
        end else if (w_accept) begin
            case (r_state)
                WAIT_R:  w_state_nxt = WAIT_G;
                WAIT_G:  w_state_nxt = WAIT_B;
                WAIT_B:  w_state_nxt = HOLD;
                default: w_state_nxt = r_state;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = WAIT_R;
            w_sync_nxt  = 1'b1;
        end else if ((r_state == HOLD) && pixel_ready) begin
            w_state_nxt = WAIT_R;
        end

        if (w_in_gb && !w_accept && (w_state_nxt == r_state)) begin
            w_idle_nxt = r_idle + 16'd1;
        end else begin
            w_idle_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= WAIT_R;
            r_armed     <= 1'b0;
            r_read_prev <= 1'b0;
            r_sync      <= 1'b0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_armed     <= 1'b1;
            r_read_prev <= w_accept;
            r_sync      <= w_sync_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    // pixel_out only changes when B lands, so it stays put outside HOLD.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_r     <= '0;
            r_g     <= '0;
            r_pixel <= '0;
        end else if (w_accept && !w_drop) begin
            case (r_state)
                WAIT_R:  r_r     <= rx_data;
                WAIT_G:  r_g     <= rx_data;
                WAIT_B:  r_pixel <= {r_r, r_g, rx_data};
                default: r_pixel <= r_pixel;
            endcase
        end
    end

`ifdef PIXEL_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_cnt <= '0;
        end else if (w_sync_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign data_read   = w_accept;
    assign pixel_out   = r_pixel;
    assign pixel_valid = (r_state == HOLD);
    assign sync_error  = r_sync;

endmodule

// File: tb/tb_pixel_assembler.sv
// Directed bench for pixel_assembler with a byte-queue reference model checked every cycle.
module tb_pixel_assembler;

    localparam int TO = 50;

    logic        clk;
    logic        n_rst;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;
    logic        data_read;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        sync_error;
`ifdef PIXEL_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    pixel_assembler #(.IDLE_TIMEOUT(TO)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .data_read     (data_read),
        .pixel_out     (pixel_out),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .sync_error    (sync_error)
`ifdef PIXEL_ERR_COUNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: partial pixel kept as a byte queue, full pixel held until taken.
    logic [7:0]  m_bytes[$];
    logic [7:0]  n_bytes[$];
    logic        m_hold, n_hold;
    logic [23:0] m_out, n_out;
    int          m_idle, n_idle;
    logic        m_sync, n_sync;
    logic        m_prev_read, m_armed, e_read;
    int          m_err;

    // Observed-event bookkeeping for the literal scenario checks.
    int          cyc = 0;
    int          reads = 0, syncs = 0, valids = 0;
    int          last_read_cyc = 0, last_sync_cyc = 0;
    logic [23:0] last_pix = '0;

    task automatic model_reset();
        m_bytes.delete();
        m_hold      = 1'b0;
        m_out       = '0;
        m_idle      = 0;
        m_sync      = 1'b0;
        m_prev_read = 1'b0;
        m_armed     = 1'b0;
        m_err       = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!n_rst) model_reset();
            cyc++;
            if (data_read) begin reads++; last_read_cyc = cyc; end
            if (sync_error) begin syncs++; last_sync_cyc = cyc; end
            if (pixel_valid) begin valids++; last_pix = pixel_out; end

            e_read = m_armed && !m_hold && data_ready && !m_prev_read;
            chk("data_read", {31'd0, data_read}, {31'd0, e_read});
            chk("pixel_valid", {31'd0, pixel_valid}, {31'd0, m_hold});
            chk("pixel_out", {8'd0, pixel_out}, {8'd0, m_out});
            chk("sync_error", {31'd0, sync_error}, {31'd0, m_sync});
`ifdef PIXEL_ERR_COUNT_EN
            chk("err_count", {24'd0, err_count}, m_err);
`endif

            n_bytes = m_bytes;
            n_hold  = m_hold;
            n_out   = m_out;
            n_idle  = 0;
            n_sync  = 1'b0;
            if (!m_hold && (overrun_error || (e_read && framing_error))) begin
                n_bytes.delete();
                n_sync = 1'b1;
            end else if (e_read) begin
                n_bytes.push_back(rx_data);
                if (n_bytes.size() == 3) begin
                    n_out  = {n_bytes[0], n_bytes[1], n_bytes[2]};
                    n_hold = 1'b1;
                    n_bytes.delete();
                end
            end else if (!m_hold && m_bytes.size() > 0) begin
                if (m_idle == TO - 1) begin
                    n_bytes.delete();
                    n_sync = 1'b1;
                end else begin
                    n_idle = m_idle + 1;
                end
            end else if (m_hold && pixel_ready) begin
                n_hold = 1'b0;
            end

            @(posedge clk);
            if (!n_rst) begin
                model_reset();
            end else begin
                m_bytes     = n_bytes;
                m_hold      = n_hold;
                m_out       = n_out;
                m_idle      = n_idle;
                m_sync      = n_sync;
                m_prev_read = e_read;
                m_armed     = 1'b1;
                if (n_sync && m_err < 255) m_err++;
            end
        end
    end

    // Offer a byte and wait for its acknowledge; data_ready stays high afterwards.
    task automatic send_byte(input logic [7:0] b, input logic fe);
        bit got;
        rx_data       = b;
        framing_error = fe;
        data_ready    = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (data_read) got = 1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_ack: byte %0h got no data_read, expected one", b);
        end
        @(posedge clk);
        #1;
        framing_error = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        data_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_byte(p[23:16], 1'b0);
        send_byte(p[15:8], 1'b0);
        send_byte(p[7:0], 1'b0);
        idle_cycles(3);
    endtask

    int r0, s0, v0;

    initial begin
        n_rst         = 1'b0;
        rx_data       = '0;
        data_ready    = 1'b0;
        overrun_error = 1'b0;
        framing_error = 1'b0;
        pixel_ready   = 1'b1;

        // Reset state, with a byte offered to show it is not consumed.
        repeat (2) @(posedge clk);
        #1;
        data_ready = 1'b1;
        rx_data    = 8'h99;
        #1;
        chk("rst_data_read", {31'd0, data_read}, 32'd0);
        chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_pixel_out", {8'd0, pixel_out}, 32'h0);
        chk("rst_sync", {31'd0, sync_error}, 32'd0);
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle_cycles(2);

        // Basic pixel, data_ready held across the ignore cycle.
        r0 = reads; s0 = syncs; v0 = valids;
        send_pixel(24'hD52A7F);
        chk("basic_reads", reads - r0, 3);
        chk("basic_syncs", syncs - s0, 0);
        chk("basic_valid_cycles", valids - v0, 1);
        chk("basic_pixel", {8'd0, last_pix}, 32'hD52A7F);

        // Backpressure: valid held 20 cycles, fourth byte waits.
        pixel_ready = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        rx_data = 8'h44;
        r0 = reads; v0 = valids;
        repeat (19) @(posedge clk);
        #1;
        pixel_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_cycles", valids - v0, 20);
        chk("bp_no_read", reads - r0, 0);
        chk("bp_pixel", {8'd0, last_pix}, 32'h010203);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        idle_cycles(3);
        chk("bp_next_pixel", {8'd0, last_pix}, 32'h445566);

        // Framing error on G drops the partial pixel.
        r0 = reads; s0 = syncs;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        idle_cycles(3);
        chk("fe_reads", reads - r0, 2);
        chk("fe_syncs", syncs - s0, 1);
        send_pixel(24'h334455);
        chk("fe_clean_pixel", {8'd0, last_pix}, 32'h334455);

        // Idle timeout after R.
        s0 = syncs;
        send_byte(8'hAA, 1'b0);
        idle_cycles(60);
        chk("to_syncs", syncs - s0, 1);
        chk("to_latency", last_sync_cyc - last_read_cyc, 51);
        send_pixel(24'hBBCCDD);
        chk("to_next_is_r", {8'd0, last_pix}, 32'hBBCCDD);

        // Accept on the timeout cycle wins.
        s0 = syncs;
        send_byte(8'hC1, 1'b0);
        data_ready = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        idle_cycles(3);
        chk("to_accept_wins_sync", syncs - s0, 0);
        chk("to_accept_wins_pixel", {8'd0, last_pix}, 32'hC1C2C3);

        // Overrun alone, then overrun together with framing error.
        r0 = reads; s0 = syncs;
        send_byte(8'h10, 1'b0);
        data_ready    = 1'b0;
        overrun_error = 1'b1;
        @(posedge clk);
        #1;
        overrun_error = 1'b0;
        idle_cycles(2);
        chk("ovr_reads", reads - r0, 1);
        chk("ovr_syncs", syncs - s0, 1);
        s0 = syncs;
        rx_data       = 8'h5A;
        data_ready    = 1'b1;
        framing_error = 1'b1;
        overrun_error = 1'b1;
        @(negedge clk);
        chk("both_read", {31'd0, data_read}, 32'd1);
        @(posedge clk);
        #1;
        framing_error = 1'b0;
        overrun_error = 1'b0;
        idle_cycles(3);
        chk("both_single_sync", syncs - s0, 1);
        send_pixel(24'hE1E2E3);
        chk("ovr_clean_pixel", {8'd0, last_pix}, 32'hE1E2E3);

        // Reset mid-pixel, then reset while holding a pixel.
        s0 = syncs;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rx_data = 8'h03;
        n_rst   = 1'b0;
        #1;
        chk("mid_rst_read", {31'd0, data_read}, 32'd0);
        chk("mid_rst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("mid_rst_out", {8'd0, pixel_out}, 32'h0);
        idle_cycles(2);
        n_rst = 1'b1;
        send_pixel(24'h123456);
        chk("mid_rst_pixel", {8'd0, last_pix}, 32'h123456);
        pixel_ready = 1'b0;
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b0);
        data_ready = 1'b0;
        chk("hold_before_rst", {31'd0, pixel_valid}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("hold_rst_valid", {31'd0, pixel_valid}, 32'd0);
        idle_cycles(2);
        n_rst       = 1'b1;
        pixel_ready = 1'b1;
        idle_cycles(3);
        chk("rst_no_sync", syncs - s0, 0);

`ifdef PIXEL_ERR_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i), 1'b1);
        end
        idle_cycles(3);
        chk("err_count_sat", {24'd0, err_count}, 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
